memory_dumper: RTL and testbench

- Read-back counterpart to the program loader: streams a contiguous range of the 32x8 unified RAM out of the system, one byte per valid/ready transfer.
- Used after loading or after execution to verify memory contents.
- Drives the RAM read port through the top-level memory mux while its `mem_req` output is high.
- Accumulates a running XOR checksum of all bytes sent.

---
 rtl/memory_dumper.sv | 177 +++++++++++++++++
 tb/tb_memory_dumper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_dumper.sv
// memory_dumper
//   Streams a contiguous, possibly wrapping, address range of the unified
//   RAM out through a valid/ready byte port. The XOR checksum covers every
//   byte the sink accepted since the last start.
//
// Ports
//   clock, reset      : system clock; asynchronous active-low reset
//   start             : begin a dump (honoured only while idle)
//   abort             : drop the dump in progress, no done pulse
//   start_addr        : first RAM address of the range, latched on start
//   end_addr          : last RAM address of the range (inclusive), latched on start
//   mem_req           : dumper owns the RAM read port (mux select)
//   mem_addr          : RAM read address
//   mem_read_data     : RAM read data, valid READ_LATENCY cycles after mem_addr
//   out_data/out_addr : byte on offer and its RAM address
//   out_valid         : out_data/out_addr are valid
//   out_ready         : sink accepts the byte
//   busy              : high from accepted start until back in idle
//   done              : one-cycle pulse after the last byte was accepted
//   checksum          : XOR of all accepted bytes since the last start
//   dbg_state         : current FSM state
//
// Handshake: a byte moves on a rising edge where out_valid & out_ready are
// both high. Once out_valid is raised, out_data/out_addr stay frozen and
// out_valid stays high until that transfer, except on abort or reset.
// out_ready is ignored while out_valid is low.
module memory_dumper #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [2:0]        dbg_state
);

  // remaining holds 1..2^ADDR_W, so it needs one extra bit.
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WAIT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(READ_LATENCY);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cur_addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] checksum_q;

  logic [ADDR_W-1:0] span;
  logic              xfer;
  logic              wait_done;
  logic              last_byte;
  logic              kill;

  // Modular difference makes end < start wrap through the top of memory,
  // and start == end+1 yield the full 2^ADDR_W bytes.
  assign span      = end_addr - start_addr;
  assign xfer      = out_valid_q & out_ready;
  assign wait_done = (wait_q == WAIT_ONE);
  assign last_byte = (remaining_q == CNT_ONE);
  assign kill      = abort & (state_q != S_IDLE);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides everything outside idle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: if (wait_done) state_d = S_SEND;
      S_SEND: if (xfer) state_d = last_byte ? S_FIN : S_REQ;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill) state_d = S_IDLE;
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    mem_req   = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    dbg_state = state_q;
  end

  // Datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      mem_addr_q  <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      checksum_q  <= '0;
    end else if (kill) begin
      // An abort coinciding with a handshake cancels that byte: no XOR.
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_addr_q  <= start_addr;
            remaining_q <= {1'b0, span} + CNT_ONE;
            checksum_q  <= '0;
          end
        end
        S_REQ: begin
          mem_addr_q <= cur_addr_q;
          wait_q     <= WAIT_LOAD;
        end
        S_WAIT: begin
          wait_q <= wait_q - WAIT_ONE;
          if (wait_done) begin
            out_data_q  <= mem_read_data;
            out_addr_q  <= cur_addr_q;
            out_valid_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            checksum_q  <= checksum_q ^ out_data_q;
            remaining_q <= remaining_q - CNT_ONE;
            if (!last_byte) cur_addr_q <= cur_addr_q + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_valid = out_valid_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_memory_dumper.sv
// Bench for memory_dumper: a RAM array, a queue-based expectation model of
// the dump stream, a per-cycle compare process and directed + random dumps.
module tb_memory_dumper;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start, abort, out_ready;
  logic [4:0] start_addr, end_addr;
  logic       mem_req, out_valid, busy, done;
  logic [4:0] mem_addr, out_addr;
  logic [7:0] mem_read_data, out_data, checksum;
  logic [2:0] dbg_state;

  logic [7:0] ram [32];
  assign mem_read_data = ram[mem_addr];

  memory_dumper #(.ADDR_W(5), .DATA_W(8), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .start_addr(start_addr), .end_addr(end_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_read_data(mem_read_data),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .checksum(checksum),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];   // {addr, data} in expected transfer order
  logic [7:0]  exp_sum;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  bit          check_en = 0;
  bit          hold_pending = 0;
  bit          sum_pending = 0;
  logic [7:0]  hold_data;
  logic [4:0]  hold_addr;
  logic [12:0] e_item;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset && check_en) begin
      if (sum_pending) begin
        checks++;
        if (checksum !== exp_sum) begin
          failures++;
          $display("FAIL running_checksum: got 0x%0h expected 0x%0h at %0t", checksum, exp_sum, $time);
        end
      end
      sum_pending = 0;
      if (hold_pending) begin
        checks++;
        if (!(out_valid === 1'b1 && out_data === hold_data && out_addr === hold_addr)) begin
          failures++;
          $display("FAIL hold_stable: got v=%0b d=0x%0h a=%0d expected v=1 d=0x%0h a=%0d at %0t",
                   out_valid, out_data, out_addr, hold_data, hold_addr, $time);
        end
      end
      if (out_valid && out_ready && !abort) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_xfer: got a=%0d d=0x%0h expected no transfer at %0t", out_addr, out_data, $time);
        end else begin
          e_item = exp_q.pop_front();
          if ({out_addr, out_data} !== e_item) begin
            failures++;
            $display("FAIL xfer: got a=%0d d=0x%0h expected a=%0d d=0x%0h at %0t",
                     out_addr, out_data, e_item[12:8], e_item[7:0], $time);
          end
          exp_sum = exp_sum ^ e_item[7:0];
          sum_pending = 1;
        end
        xfer_cnt++;
      end
      if (done) begin
        checks++;
        if (exp_q.size() != 0 || checksum !== exp_sum) begin
          failures++;
          $display("FAIL done_state: got left=%0d sum=0x%0h expected left=0 sum=0x%0h at %0t",
                   exp_q.size(), checksum, exp_sum, $time);
        end
        done_cnt++;
      end
      hold_pending = out_valid && !out_ready && !abort;
      hold_data    = out_data;
      hold_addr    = out_addr;
    end else begin
      hold_pending = 0;
      sum_pending  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_req"},   32'(mem_req),   0);
    chk({tag, "_mem_addr"},  32'(mem_addr),  0);
    chk({tag, "_out_data"},  32'(out_data),  0);
    chk({tag, "_out_addr"},  32'(out_addr),  0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"},      32'(busy),      0);
    chk({tag, "_done"},      32'(done),      0);
    chk({tag, "_checksum"},  32'(checksum),  0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: stall byte index 1 for
  // five valid cycles and pulse a stray start mid-dump.
  // abort_at >= 0: abort while byte index abort_at is on offer.
  task automatic run_dump(input logic [4:0] s, input logic [4:0] e, input int mode,
                          input int abort_at, output int n_xfer, output int cyc);
    logic [4:0] d, a;
    int len, base_x, base_d, stall;
    bit aborted;
    d = e - s;
    len = int'(d) + 1;
    for (int i = 0; i < len; i++) begin
      a = s + 5'(i);
      exp_q.push_back({a, ram[a]});
    end
    exp_sum = 8'h00;
    base_x = xfer_cnt;
    base_d = done_cnt;
    stall = 0;
    aborted = 0;
    cyc = 0;
    start_addr = s;
    end_addr = e;
    start = 1;
    @(posedge clock); #1;
    start = 0;
    chk("busy_after_start", 32'(busy), 1);
    chk("checksum_cleared", 32'(checksum), 0);
    while (done_cnt == base_d && cyc < 3000) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && (xfer_cnt - base_x) == 1 && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      if (mode == 2 && cyc == 3) begin
        start = 1'b1;
        start_addr = 5'd20;
        end_addr = 5'd21;
      end else begin
        start = 1'b0;
      end
      if (abort_at >= 0 && out_valid && (xfer_cnt - base_x) == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b1;
      end
      @(posedge clock); #1;
      cyc++;
      if (abort) begin
        abort = 1'b0;
        aborted = 1;
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_mem_req", 32'(mem_req), 0);
        break;
      end
    end
    start = 1'b0;
    if (aborted) begin
      exp_q.delete();
    end else begin
      chk("dump_finished_in_time", 32'(done_cnt - base_d), 1);
      chk("busy_after_done", 32'(busy), 0);
      chk("done_single_pulse", 32'(done), 0);
      if (done_cnt == base_d) exp_q.delete();
    end
    out_ready = 1'b0;
    n_xfer = xfer_cnt - base_x;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, cyc, dc;
    logic [7:0] x;
    logic [4:0] rs, re;
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; end_addr = '0;
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
    #12;
    check_all_zero("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    check_en = 1;
    @(posedge clock); #1;

    // Basic 4-byte dump, full throughput
    ram[4] = 8'h11; ram[5] = 8'h22; ram[6] = 8'h44; ram[7] = 8'h88;
    run_dump(5'd4, 5'd7, 0, -1, n, cyc);
    chk("t1_count", 32'(n), 4);
    chk("t1_checksum", 32'(checksum), 32'h0FF);
    chk("t1_model_sum", 32'(exp_sum), 32'h0FF);
    chk("t1_cycles", 32'(cyc), 13);

    // Wrapping range
    ram[30] = 8'hA5; ram[31] = 8'h5A; ram[0] = 8'h0F;
    run_dump(5'd30, 5'd0, 0, -1, n, cyc);
    chk("t2_count", 32'(n), 3);
    chk("t2_checksum", 32'(checksum), 32'h0F0);

    // Single byte
    ram[9] = 8'h3C;
    run_dump(5'd9, 5'd9, 1, -1, n, cyc);
    chk("t3_count", 32'(n), 1);
    chk("t3_checksum", 32'(checksum), 32'h03C);

    // Backpressure on byte 2 plus an ignored mid-dump start
    x = 8'h00;
    for (int i = 3; i <= 7; i++) x = x ^ ram[i];
    run_dump(5'd3, 5'd7, 2, -1, n, cyc);
    chk("t4_count", 32'(n), 5);
    chk("t4_checksum", 32'(checksum), 32'(x));

    // Abort on byte index 10
    dc = done_cnt;
    x = 8'h00;
    for (int i = 0; i <= 9; i++) x = x ^ ram[i];
    run_dump(5'd0, 5'd31, 0, 10, n, cyc);
    chk("t5_count", 32'(n), 10);
    chk("t5_checksum", 32'(checksum), 32'(x));
    @(posedge clock); #1;
    chk("t5_no_done", 32'(done_cnt - dc), 0);
    chk("t5_idle_busy", 32'(busy), 0);

    // Asynchronous reset mid-dump, then a full-range dump
    check_en = 0;
    start_addr = 5'd0; end_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #4 reset = 1'b0;
    #1 check_all_zero("midreset");
    out_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check_en = 1;
    @(posedge clock); #1;
    x = 8'h00;
    for (int i = 0; i < 32; i++) x = x ^ ram[i];
    run_dump(5'd0, 5'd31, 1, -1, n, cyc);
    chk("t6_count", 32'(n), 32);
    chk("t6_checksum", 32'(checksum), 32'(x));

    // Random ranges, random RAM, random backpressure
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
      rs = 5'($urandom_range(0, 31));
      re = 5'($urandom_range(0, 31));
      run_dump(rs, re, 1, -1, n, cyc);
      chk("rand_count", 32'(n), 32'(int'(5'(re - rs)) + 1));
    end

    repeat (3) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
